// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, h/v counters, registered sync/blank decode.
// Optional `VGA_FRAME_COUNTER_EN adds a 16-bit frame counter output (frame_cnt).
module vga_timing_gen #(
  parameter int CLK_MHZ   = 50,
  parameter int PIXEL_MHZ = 25,
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int W_X       = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK),
  parameter int W_Y       = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic [W_X-1:0] hpos,
  output logic [W_Y-1:0] vpos,
  output logic           pixel_clk,
  output logic           line_start,
  output logic           frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [15:0]    frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV     = (PIXEL_MHZ > 0) ? CLK_MHZ / PIXEL_MHZ : 1;
  localparam int W_D     = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [W_D-1:0] DIV_LAST = W_D'(DIV - 1);
  localparam logic [W_X-1:0] H_LAST   = W_X'(H_TOTAL - 1);
  localparam logic [W_Y-1:0] V_LAST   = W_Y'(V_TOTAL - 1);
  localparam logic           HS_ON    = (HSYNC_POL != 0);
  localparam logic           VS_ON    = (VSYNC_POL != 0);

  generate
    if (PIXEL_MHZ < 1 || CLK_MHZ < PIXEL_MHZ || (CLK_MHZ % PIXEL_MHZ) != 0) begin : g_bad_ratio
      $error("vga_timing_gen: CLK_MHZ must be a positive multiple of PIXEL_MHZ");
    end
  endgenerate

  function automatic logic hsync_at(input logic [W_X-1:0] h);
    return (int'(h) >= H_ACTIVE + H_FRONT && int'(h) < H_ACTIVE + H_FRONT + H_SYNC) ? HS_ON : ~HS_ON;
  endfunction

  function automatic logic vsync_at(input logic [W_Y-1:0] v);
    return (int'(v) >= V_ACTIVE + V_FRONT && int'(v) < V_ACTIVE + V_FRONT + V_SYNC) ? VS_ON : ~VS_ON;
  endfunction

  function automatic logic active_at(input logic [W_X-1:0] h, input logic [W_Y-1:0] v);
    return (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  endfunction

  logic [W_D-1:0] div_cnt;
  logic [W_D-1:0] div_nxt;
  logic [W_X-1:0] h_nxt;
  logic [W_Y-1:0] v_nxt;
  logic           tick;
  logic           line_hit;
  logic           frame_hit;

  always_comb begin
    tick    = en && (div_cnt == DIV_LAST);
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + W_D'(1);
    h_nxt   = hpos + W_X'(1);
    v_nxt   = vpos;
    if (hpos == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vpos == V_LAST) ? '0 : vpos + W_Y'(1);
    end
    line_hit  = tick && (h_nxt == '0);
    frame_hit = line_hit && (v_nxt == '0);
  end

  // Outputs are decoded from the next position so they stay aligned with hpos/vpos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      display_on  <= 1'b0;
      pixel_clk   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_clk   <= tick;
      line_start  <= line_hit;
      frame_start <= frame_hit;
      if (en) begin
        div_cnt <= div_nxt;
      end
      if (tick) begin
        hpos       <= h_nxt;
        vpos       <= v_nxt;
        hsync      <= hsync_at(h_nxt);
        vsync      <= vsync_at(v_nxt);
        display_on <= active_at(h_nxt, v_nxt);
      end
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_hit) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
